// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared key codes, widths and FSM state encoding for the keypad front-end
package atm_pkg;

    localparam logic [3:0] KEY_CLEAR  = 4'hA;
    localparam logic [3:0] KEY_ENTER  = 4'hB;
    localparam logic [3:0] KEY_CANCEL = 4'hC;

    localparam int ACC_W   = 12;
    localparam int PIN_W   = 4;
    localparam int ACC_MAX = 4095;
    localparam int PIN_MAX = 15;

    typedef enum logic [2:0] {
        ST_ACC_ENTRY = 3'd0,
        ST_PIN_ENTRY = 3'd1,
        ST_REQUEST   = 3'd2,
        ST_WAIT_AUTH = 3'd3,
        ST_SESSION   = 3'd4,
        ST_LOCKED    = 3'd5
    } state_t;

endpackage

// File: rtl/bcd_accumulator.sv
// rtl/bcd_accumulator.sv - decimal digit accumulator with value and digit-count limits
//   clk, rst  : clock, synchronous active-high reset
//   clear     : zero value and digit count (wins over load)
//   load      : append digit when digit_ok
//   digit     : decimal digit 0-9
//   value     : accumulated value
//   count     : digits currently held
//   digit_ok  : appending digit would stay within both limits
module bcd_accumulator #(
    parameter int W          = 12,
    parameter int MAX_VAL    = 4095,
    parameter int MAX_DIGITS = 4,
    parameter int CW         = $clog2(MAX_DIGITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          load,
    input  logic [3:0]    digit,
    output logic [W-1:0]  value,
    output logic [CW-1:0] count,
    output logic          digit_ok
);

    logic [W-1:0]  value_q, value_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   val_next;

    always_comb begin
        // 16-bit intermediate so the overflow check itself cannot wrap
        val_next = 16'(value_q) * 16'd10 + {12'd0, digit};
        digit_ok = (count_q < CW'(MAX_DIGITS)) && (val_next <= 16'(MAX_VAL));
        value_d  = value_q;
        count_d  = count_q;
        if (clear) begin
            value_d = '0;
            count_d = '0;
        end else if (load && digit_ok) begin
            value_d = val_next[W-1:0];
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
            count_q <= '0;
        end else begin
            value_q <= value_d;
            count_q <= count_d;
        end
    end

    assign value = value_q;
    assign count = count_q;

endmodule

// File: rtl/atm_keypad_entry.sv
// rtl/atm_keypad_entry.sv - keypad front-end: account/PIN entry, auth wait, lockout, session exit
//   clk, rst              : clock, synchronous active-high reset
//   key_valid, key_code   : one key per strobe (0-9 digit, A clear, B enter, C cancel)
//   auth_result_valid     : verdict strobe, auth_ok sampled with it
//   accNumber, pin        : registered credentials, nonzero only from REQUEST to session end
//   auth_req, exit        : registered one-cycle pulses
//   entry_error           : registered one-cycle pulse on a rejected key
//   session_active, locked: state levels
//   fail_count            : consecutive failed authentications
module atm_keypad_entry
    import atm_pkg::*;
#(
    parameter int MAX_ATTEMPTS = 3,
    parameter int LOCK_CYCLES  = 16,
    parameter int AUTH_TIMEOUT = 8,
    parameter int ACC_DIGITS   = 4,
    parameter int PIN_DIGITS   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    input  logic [3:0]        key_code,
    input  logic              auth_result_valid,
    input  logic              auth_ok,
    output logic [ACC_W-1:0]  accNumber,
    output logic [PIN_W-1:0]  pin,
    output logic              auth_req,
    output logic              session_active,
    output logic              exit,
    output logic              locked,
    output logic              entry_error,
    output logic [2:0]        fail_count
);

    localparam int ACC_CW = $clog2(ACC_DIGITS + 1);
    localparam int PIN_CW = $clog2(PIN_DIGITS + 1);
    localparam int TMR_W  = $clog2(AUTH_TIMEOUT + 1);
    localparam int LCK_W  = $clog2(LOCK_CYCLES + 1);

    state_t             state_q, state_d;
    logic [2:0]         fail_q, fail_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [LCK_W-1:0]   lock_q, lock_d;
    logic [ACC_W-1:0]   acc_out_q, acc_out_d;
    logic [PIN_W-1:0]   pin_out_q, pin_out_d;
    logic               auth_req_q, auth_req_d;
    logic               exit_q, exit_d;
    logic               err_q, err_d;

    logic               acc_clear, acc_load, acc_ok;
    logic               pin_clear, pin_load, pin_ok;
    logic [ACC_W-1:0]   acc_value;
    logic [PIN_W-1:0]   pin_value;
    logic [ACC_CW-1:0]  acc_count;
    logic [PIN_CW-1:0]  pin_count;

    logic               is_digit;
    logic               fail_now;
    logic [2:0]         fail_inc;

    bcd_accumulator #(
        .W(ACC_W), .MAX_VAL(ACC_MAX), .MAX_DIGITS(ACC_DIGITS), .CW(ACC_CW)
    ) u_acc (
        .clk(clk), .rst(rst), .clear(acc_clear), .load(acc_load), .digit(key_code),
        .value(acc_value), .count(acc_count), .digit_ok(acc_ok)
    );

    bcd_accumulator #(
        .W(PIN_W), .MAX_VAL(PIN_MAX), .MAX_DIGITS(PIN_DIGITS), .CW(PIN_CW)
    ) u_pin (
        .clk(clk), .rst(rst), .clear(pin_clear), .load(pin_load), .digit(key_code),
        .value(pin_value), .count(pin_count), .digit_ok(pin_ok)
    );

    always_comb begin
        is_digit = (key_code <= 4'd9);
        fail_inc = fail_q + 3'd1;
        // A verdict in the expiry cycle is checked first, so it beats the timeout
        fail_now = (state_q == ST_WAIT_AUTH) &&
                   (auth_result_valid ? !auth_ok : (timer_q == '0));

        state_d    = state_q;
        fail_d     = fail_q;
        timer_d    = timer_q;
        lock_d     = lock_q;
        acc_out_d  = acc_out_q;
        pin_out_d  = pin_out_q;
        auth_req_d = 1'b0;
        exit_d     = 1'b0;
        err_d      = 1'b0;
        acc_clear  = 1'b0;
        acc_load   = 1'b0;
        pin_clear  = 1'b0;
        pin_load   = 1'b0;

        case (state_q)
            ST_ACC_ENTRY: begin
                if (key_valid) begin
                    if (is_digit) begin
                        if (acc_ok) acc_load = 1'b1;
                        else        err_d    = 1'b1;
                    end else if (key_code == KEY_CLEAR || key_code == KEY_CANCEL) begin
                        acc_clear = 1'b1;
                    end else if (key_code == KEY_ENTER) begin
                        if (acc_count == '0) err_d   = 1'b1;
                        else                 state_d = ST_PIN_ENTRY;
                    end
                end
            end
            ST_PIN_ENTRY: begin
                if (key_valid) begin
                    if (is_digit) begin
                        if (pin_ok) pin_load = 1'b1;
                        else        err_d    = 1'b1;
                    end else if (key_code == KEY_CLEAR) begin
                        pin_clear = 1'b1;
                    end else if (key_code == KEY_CANCEL) begin
                        acc_clear = 1'b1;
                        pin_clear = 1'b1;
                        state_d   = ST_ACC_ENTRY;
                    end else if (key_code == KEY_ENTER) begin
                        if (pin_count == '0) begin
                            err_d = 1'b1;
                        end else begin
                            // Credentials move to the output registers; the entry
                            // buffers are emptied now so every later exit path
                            // lands in ACC_ENTRY with clean buffers.
                            acc_out_d  = acc_value;
                            pin_out_d  = pin_value;
                            acc_clear  = 1'b1;
                            pin_clear  = 1'b1;
                            auth_req_d = 1'b1;
                            state_d    = ST_REQUEST;
                        end
                    end
                end
            end
            ST_REQUEST: begin
                // Counts down to zero, so WAIT_AUTH spans exactly AUTH_TIMEOUT cycles
                timer_d = TMR_W'(AUTH_TIMEOUT - 1);
                state_d = ST_WAIT_AUTH;
            end
            ST_WAIT_AUTH: begin
                if (auth_result_valid && auth_ok) begin
                    fail_d  = 3'd0;
                    state_d = ST_SESSION;
                end else if (fail_now) begin
                    fail_d    = fail_inc;
                    acc_out_d = '0;
                    pin_out_d = '0;
                    if (fail_inc == 3'(MAX_ATTEMPTS)) begin
                        lock_d  = LCK_W'(LOCK_CYCLES - 1);
                        state_d = ST_LOCKED;
                    end else begin
                        state_d = ST_ACC_ENTRY;
                    end
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            ST_SESSION: begin
                if (key_valid && key_code == KEY_CANCEL) begin
                    exit_d    = 1'b1;
                    acc_out_d = '0;
                    pin_out_d = '0;
                    state_d   = ST_ACC_ENTRY;
                end
            end
            ST_LOCKED: begin
                if (lock_q == '0) begin
                    fail_d  = 3'd0;
                    state_d = ST_ACC_ENTRY;
                end else begin
                    lock_d = lock_q - LCK_W'(1);
                end
            end
            default: state_d = ST_ACC_ENTRY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ACC_ENTRY;
            fail_q     <= '0;
            timer_q    <= '0;
            lock_q     <= '0;
            acc_out_q  <= '0;
            pin_out_q  <= '0;
            auth_req_q <= 1'b0;
            exit_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fail_q     <= fail_d;
            timer_q    <= timer_d;
            lock_q     <= lock_d;
            acc_out_q  <= acc_out_d;
            pin_out_q  <= pin_out_d;
            auth_req_q <= auth_req_d;
            exit_q     <= exit_d;
            err_q      <= err_d;
        end
    end

    assign accNumber      = acc_out_q;
    assign pin            = pin_out_q;
    assign auth_req       = auth_req_q;
    assign exit           = exit_q;
    assign entry_error    = err_q;
    assign fail_count     = fail_q;
    assign session_active = (state_q == ST_SESSION);
    assign locked         = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_atm_keypad_entry.sv
// tb/tb_atm_keypad_entry.sv - scoreboard bench for atm_keypad_entry
module tb_atm_keypad_entry;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        auth_result_valid;
    logic        auth_ok;
    logic [11:0] accNumber;
    logic [3:0]  pin;
    logic        auth_req, session_active, exit, locked, entry_error;
    logic [2:0]  fail_count;

    always #5 clk = ~clk;

    atm_keypad_entry dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .auth_result_valid(auth_result_valid), .auth_ok(auth_ok),
        .accNumber(accNumber), .pin(pin), .auth_req(auth_req),
        .session_active(session_active), .exit(exit), .locked(locked),
        .entry_error(entry_error), .fail_count(fail_count)
    );

    localparam int K_ERR = 0, K_REQ = 1, K_EXIT = 2, K_SESS = 3, K_FC = 4, K_LOCK = 5;
    localparam int M_ACC = 0, M_PIN = 1, M_AUTH = 2, M_SESS = 3;
    localparam int LOCK_LEN = 16, TIMEOUT = 8, MAX_TRIES = 3;

    typedef struct {
        int kind;
        int a;
        int b;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    // Reference model: credentials as plain integers, entry phase as a mode number
    int mode, acc_v, acc_n, pin_v, pin_n, fails;

    function automatic void push(int k, int a, int b);
        ev_t e;
        e.kind = k; e.a = a; e.b = b;
        exp_q.push_back(e);
    endfunction

    function automatic void model_reset();
        mode = M_ACC; acc_v = 0; acc_n = 0; pin_v = 0; pin_n = 0; fails = 0;
    endfunction

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic take(input int kind, input int a, input int b, input string name,
                        output int ea, output int eb);
        ev_t e;
        n_cmp++;
        ea = 0; eb = 0;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: got unexpected event kind %0d (%0d,%0d), want no event", name, kind, a, b);
        end else begin
            e = exp_q.pop_front();
            ea = e.a; eb = e.b;
            if (e.kind != kind || e.a != a || e.b != b) begin
                n_bad++;
                $display("FAIL %s: got kind %0d (%0d,%0d), want kind %0d (%0d,%0d)",
                         name, kind, a, b, e.kind, e.a, e.b);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_key(input int c);
        int nv;
        case (mode)
            M_ACC: begin
                if (c <= 9) begin
                    nv = acc_v * 10 + c;
                    if (acc_n >= 4 || nv > 4095) push(K_ERR, 0, 0);
                    else begin acc_v = nv; acc_n++; end
                end else if (c == 10 || c == 12) begin
                    acc_v = 0; acc_n = 0;
                end else if (c == 11) begin
                    if (acc_n == 0) push(K_ERR, 0, 0);
                    else mode = M_PIN;
                end
            end
            M_PIN: begin
                if (c <= 9) begin
                    nv = pin_v * 10 + c;
                    if (pin_n >= 2 || nv > 15) push(K_ERR, 0, 0);
                    else begin pin_v = nv; pin_n++; end
                end else if (c == 10) begin
                    pin_v = 0; pin_n = 0;
                end else if (c == 12) begin
                    model_reset_bufs();
                    mode = M_ACC;
                end else if (c == 11) begin
                    if (pin_n == 0) push(K_ERR, 0, 0);
                    else begin
                        push(K_REQ, acc_v, pin_v);
                        model_reset_bufs();
                        mode = M_AUTH;
                    end
                end
            end
            M_SESS: begin
                if (c == 12) begin
                    push(K_EXIT, 0, 0);
                    mode = M_ACC;
                end
            end
            default: ;
        endcase
    endtask

    function automatic void model_reset_bufs();
        acc_v = 0; acc_n = 0; pin_v = 0; pin_n = 0;
    endfunction

    task automatic press(input int c);
        model_key(c);
        key_valid = 1'b1;
        key_code  = 4'(c);
        tick();
        key_valid = 1'b0;
    endtask

    task automatic idle();
        auth_result_valid = 1'($urandom_range(0, 1));
        auth_ok           = 1'($urandom_range(0, 1));
        tick();
        auth_result_valid = 1'b0;
    endtask

    task automatic noise();
        key_valid = 1'($urandom_range(0, 1));
        key_code  = 4'($urandom_range(0, 15));
    endtask

    // delay: WAIT_AUTH cycle index carrying the verdict; >= TIMEOUT means none
    task automatic auth(input int delay, input bit ok);
        bit lockout;
        lockout = 1'b0;
        if (delay < TIMEOUT && ok) begin
            push(K_SESS, 0, 0);
            if (fails != 0) push(K_FC, 0, 0);
            fails = 0;
            mode = M_SESS;
        end else begin
            fails++;
            push(K_FC, fails, 0);
            if (fails == MAX_TRIES) begin
                push(K_LOCK, 0, 0);
                push(K_FC, 0, 0);
                lockout = 1'b1;
                fails = 0;
            end
            mode = M_ACC;
        end
        // REQUEST cycle: a stray verdict and keys here must be ignored
        noise();
        auth_result_valid = 1'b1;
        auth_ok = 1'b1;
        tick();
        auth_result_valid = 1'b0;
        for (int k = 0; k < TIMEOUT; k++) begin
            noise();
            if (k == delay) begin
                auth_result_valid = 1'b1;
                auth_ok = ok;
            end
            tick();
            auth_result_valid = 1'b0;
            if (k == delay) break;
        end
        key_valid = 1'b0;
        if (lockout) begin
            for (int k = 0; k < LOCK_LEN; k++) begin
                noise();
                tick();
            end
            key_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        key_valid = 1'b0;
        auth_result_valid = 1'b0;
        tick();
        check("rst_accNumber", int'(accNumber), 0);
        check("rst_pin", int'(pin), 0);
        check("rst_auth_req", int'(auth_req), 0);
        check("rst_session_active", int'(session_active), 0);
        check("rst_exit", int'(exit), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_entry_error", int'(entry_error), 0);
        check("rst_fail_count", int'(fail_count), 0);
        rst = 1'b0;
        model_reset();
        exp_q.delete();
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event
    initial begin
        int prev_fc, lock_len, held_acc, held_pin, ea, eb;
        bit prev_lock, prev_sess, held;
        prev_fc = 0; lock_len = 0; held_acc = 0; held_pin = 0;
        prev_lock = 0; prev_sess = 0; held = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_fc = 0; prev_lock = 0; prev_sess = 0; lock_len = 0; held = 0;
            end else begin
                if (entry_error) take(K_ERR, 0, 0, "entry_error", ea, eb);
                if (auth_req) begin
                    take(K_REQ, int'(accNumber), int'(pin), "auth_req", ea, eb);
                    held = 1; held_acc = ea; held_pin = eb;
                end
                if (exit) begin
                    take(K_EXIT, 0, 0, "exit", ea, eb);
                    held = 0;
                end
                if (session_active && !prev_sess) take(K_SESS, 0, 0, "session_start", ea, eb);
                if (int'(fail_count) != prev_fc) begin
                    take(K_FC, int'(fail_count), 0, "fail_count", ea, eb);
                    if (int'(fail_count) > prev_fc) held = 0;
                end
                if (locked && !prev_lock) begin
                    take(K_LOCK, 0, 0, "lock_start", ea, eb);
                    lock_len = 0;
                end
                if (locked) lock_len++;
                if (!locked && prev_lock) check("lock_cycles", lock_len, LOCK_LEN);
                check("accNumber_level", int'(accNumber), held ? held_acc : 0);
                check("pin_level", int'(pin), held ? held_pin : 0);
                prev_fc = int'(fail_count);
                prev_lock = locked;
                prev_sess = session_active;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish after 400000 ns, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        rst = 1'b1;
        key_valid = 1'b0;
        key_code = 4'd0;
        auth_result_valid = 1'b0;
        auth_ok = 1'b0;
        tick();
        do_reset();

        // 2749 / 0, accepted, then cancel from the session
        press(2); press(7); press(4); press(9); press(11); press(0); press(11);
        auth(2, 1'b1);
        press(5); press(11);
        press(12);
        idle(); idle();

        // 5000 overflows, buffer keeps 500
        press(5); press(0); press(0); press(0); press(11); press(1); press(11);
        auth(1, 1'b1);
        press(12);

        // PIN value and digit limits, then three failures to lockout
        press(9); press(11); press(1); press(6); press(10);
        press(1); press(2); press(3); press(11);
        auth(0, 1'b0);
        press(1); press(11); press(1); press(11);
        auth(3, 1'b0);
        press(1); press(11); press(1); press(11);
        auth(5, 1'b0);
        idle();

        // Timeout, then a verdict on the expiry cycle wins
        press(3); press(11); press(4); press(11);
        auth(TIMEOUT + 1, 1'b1);
        press(3); press(11); press(4); press(11);
        auth(TIMEOUT - 1, 1'b1);
        press(12);

        // Enter with empty buffers, unknown keys
        press(11); press(14); press(7); press(11); press(11); press(12);

        // Reset mid-PIN with a nonzero fail count, and reset inside a session
        press(1); press(11); press(1); press(11);
        auth(0, 1'b0);
        press(4); press(11); press(7);
        do_reset();
        idle(); idle();
        press(8); press(11); press(2); press(11);
        auth(0, 1'b1);
        do_reset();
        idle(); idle();

        for (int i = 0; i < 300; i++) begin
            if (mode == M_AUTH) begin
                auth($urandom_range(0, 9), 1'($urandom_range(0, 1)));
            end else begin
                r = $urandom_range(0, 19);
                if (r <= 11)      press($urandom_range(0, 9));
                else if (r <= 14) press(11);
                else if (r == 15) press(10);
                else if (r == 16) press(12);
                else if (r == 17) press($urandom_range(13, 15));
                else              idle();
            end
        end
        if (mode == M_AUTH) auth(0, 1'b1);
        repeat (4) idle();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
